fade_sequencer: RTL and testbench

- Drives three `fade` instances (R, G, B) with 2-bit state codes so an RGB LED walks the six-segment hue wheel.
- Owns segment timing, run/pause/single-step control and wheel direction.
- The fade instances only turn codes into PWM levels. This block holds the sequencing; the top level instantiates it beside them.

---
 rtl/fade_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fade_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fade_sequencer
//  Purpose  : Steps three fade channels through the six-segment RGB hue wheel
//             with run / pause / single-step control and reversible direction.
//  Revision : 1.0  initial release
// ============================================================================
module fade_sequencer #(
    parameter int PHASE_CYCLES = 2400000,
    parameter int CNT_W        = $clog2(PHASE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pause_req,
    input  logic       step,
    input  logic       dir,
    output logic [1:0] r_state,
    output logic [1:0] g_state,
    output logic [1:0] b_state,
    output logic [2:0] segment,
    output logic       seg_done,
    output logic       running
);

    localparam logic [1:0] C_INC  = 2'b00;
    localparam logic [1:0] C_DEC  = 2'b01;
    localparam logic [1:0] C_HIGH = 2'b10;
    localparam logic [1:0] C_LOW  = 2'b11;

    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LAST_M1 = CNT_W'(PHASE_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_dir;
    logic             step_pend;

    logic [2:0] seg_fwd;
    logic [2:0] seg_rev;
    logic [2:0] adv_seg;
    logic [5:0] adv_codes;
    logic [5:0] hold_codes;

    // Reverse swaps INC<->DEC: toggle bit 0 of every ramping (bit1 = 0) field.
    function automatic logic [5:0] row_codes(input logic [2:0] seg, input logic rev);
        logic [5:0] fwd;
        case (seg)
            3'd0:    fwd = {C_HIGH, C_INC,  C_LOW };
            3'd1:    fwd = {C_DEC,  C_HIGH, C_LOW };
            3'd2:    fwd = {C_LOW,  C_HIGH, C_INC };
            3'd3:    fwd = {C_LOW,  C_DEC,  C_HIGH};
            3'd4:    fwd = {C_INC,  C_LOW,  C_HIGH};
            3'd5:    fwd = {C_HIGH, C_LOW,  C_DEC };
            default: fwd = {C_LOW,  C_LOW,  C_LOW };
        endcase
        return fwd ^ ({6{rev}} & {1'b0, ~fwd[5], 1'b0, ~fwd[3], 1'b0, ~fwd[1]});
    endfunction

    function automatic logic [1:0] hold_code(input logic [1:0] code);
        return code[1] ? code : {1'b1, code[0]};
    endfunction

    // A direction change since the last boundary replays the same segment.
    always_comb begin
        seg_fwd = (segment == 3'd5) ? 3'd0 : segment + 3'd1;
        seg_rev = (segment == 3'd0) ? 3'd5 : segment - 3'd1;
        if (dir != last_dir) begin
            adv_seg = segment;
        end else if (dir) begin
            adv_seg = seg_rev;
        end else begin
            adv_seg = seg_fwd;
        end
        adv_codes  = row_codes(adv_seg, dir);
        hold_codes = {hold_code(r_state), hold_code(g_state), hold_code(b_state)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                       <= IDLE;
            {r_state, g_state, b_state} <= {C_LOW, C_LOW, C_LOW};
            segment                     <= 3'd0;
            cnt                         <= '0;
            seg_done                    <= 1'b0;
            running                     <= 1'b0;
            last_dir                    <= 1'b0;
            step_pend                   <= 1'b0;
        end else if (!enable) begin
            state                       <= IDLE;
            {r_state, g_state, b_state} <= {C_LOW, C_LOW, C_LOW};
            cnt                         <= '0;
            seg_done                    <= 1'b0;
            running                     <= 1'b0;
            step_pend                   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state                       <= RAMP;
                    {r_state, g_state, b_state} <= {C_INC, C_LOW, C_LOW};
                    cnt                         <= '0;
                    seg_done                    <= 1'b0;
                    running                     <= 1'b1;
                end
                RAMP: begin
                    if (cnt == C_LAST) begin
                        state                       <= RUN;
                        segment                     <= dir ? 3'd5 : 3'd0;
                        {r_state, g_state, b_state} <= row_codes(dir ? 3'd5 : 3'd0, dir);
                        cnt                         <= '0;
                        seg_done                    <= 1'b0;
                        last_dir                    <= dir;
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        seg_done <= (cnt == C_LAST_M1);
                    end
                end
                RUN: begin
                    if (cnt == C_LAST) begin
                        cnt      <= '0;
                        seg_done <= 1'b0;
                        last_dir <= dir;
                        if (pause_req || step_pend) begin
                            state                       <= PAUSE;
                            {r_state, g_state, b_state} <= hold_codes;
                            step_pend                   <= 1'b0;
                            running                     <= 1'b0;
                        end else begin
                            segment                     <= adv_seg;
                            {r_state, g_state, b_state} <= adv_codes;
                        end
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        seg_done <= (cnt == C_LAST_M1);
                    end
                end
                PAUSE: begin
                    if (step || !pause_req) begin
                        state                       <= RUN;
                        segment                     <= adv_seg;
                        {r_state, g_state, b_state} <= adv_codes;
                        last_dir                    <= dir;
                        step_pend                   <= step;
                        running                     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fade_sequencer
//  Purpose  : Scoreboard bench for fade_sequencer with an 8-cycle segment.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fade_sequencer;

    localparam int C_PC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       pause_req = 1'b0;
    logic       step = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] r_state, g_state, b_state;
    logic [2:0] segment;
    logic       seg_done, running;

    fade_sequencer #(.PHASE_CYCLES(C_PC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .pause_req(pause_req),
        .step     (step),
        .dir      (dir),
        .r_state  (r_state),
        .g_state  (g_state),
        .b_state  (b_state),
        .segment  (segment),
        .seg_done (seg_done),
        .running  (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] codes;
        logic [2:0] seg;
        logic       sv;
        logic       done;
        logic       run;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic logic [5:0] row(input int s, input logic rev);
        logic [5:0] r;
        case (s)
            0:       r = 6'b10_00_11;
            1:       r = 6'b01_10_11;
            2:       r = 6'b11_10_00;
            3:       r = 6'b11_01_10;
            4:       r = 6'b00_11_10;
            default: r = 6'b10_11_01;
        endcase
        if (rev) begin
            for (int i = 0; i < 3; i++) begin
                if (r[i*2 +: 2] == 2'b00)      r[i*2 +: 2] = 2'b01;
                else if (r[i*2 +: 2] == 2'b01) r[i*2 +: 2] = 2'b00;
            end
        end
        return r;
    endfunction

    task automatic push(input logic [5:0] codes, input int s, input logic sv,
                        input logic done, input logic run);
        exp_t e;
        e.codes = codes;
        e.seg   = 3'(s);
        e.sv    = sv;
        e.done  = done;
        e.run   = run;
        sb.push_back(e);
    endtask

    task automatic push_seg(input int s, input logic rev, input int len);
        for (int i = 0; i < len; i++) push(row(s, rev), s, 1'b1, i == C_PC - 1, 1'b1);
    endtask

    task automatic push_ramp(input int len);
        for (int i = 0; i < len; i++) push(6'b00_11_11, 0, 1'b0, i == C_PC - 1, 1'b1);
    endtask

    task automatic push_idle(input int n, input logic sv);
        for (int i = 0; i < n; i++) push(6'b11_11_11, 0, sv, 1'b0, 1'b0);
    endtask

    task automatic push_pause(input logic [5:0] codes, input int s, input int n);
        for (int i = 0; i < n; i++) push(codes, s, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [12:0] got, want;
        int n;
        sb.delete();
        push_idle(4, 1'b1);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 0) begin rst_n = 1'b0; enable = 1'b1; end
            if (c == 2) enable = 1'b0;
            if (c == 3) rst_n = 1'b1;
            tick();
            e    = sb.pop_front();
            got  = {r_state, g_state, b_state, e.sv ? segment : e.seg, seg_done, running};
            want = {e.codes, e.seg, e.done, e.run};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL reset cyc %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_forward();
        exp_t e;
        logic [12:0] got, want;
        int n;
        sb.delete();
        push_ramp(C_PC);
        for (int s = 0; s < 7; s++) push_seg(s % 6, 1'b0, C_PC);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 0) begin enable = 1'b1; dir = 1'b0; end
            tick();
            e    = sb.pop_front();
            got  = {r_state, g_state, b_state, e.sv ? segment : e.seg, seg_done, running};
            want = {e.codes, e.seg, e.done, e.run};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL forward cyc %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_reverse();
        exp_t e;
        logic [12:0] got, want;
        int n;
        sb.delete();
        push_idle(1, 1'b0);
        push_ramp(C_PC);
        push_seg(5, 1'b1, C_PC);
        push_seg(4, 1'b1, C_PC);
        push_seg(3, 1'b1, C_PC);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 0) enable = 1'b0;
            if (c == 1) begin enable = 1'b1; dir = 1'b1; end
            tick();
            e    = sb.pop_front();
            got  = {r_state, g_state, b_state, e.sv ? segment : e.seg, seg_done, running};
            want = {e.codes, e.seg, e.done, e.run};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL reverse cyc %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_undo();
        exp_t e;
        logic [12:0] got, want;
        int n;
        sb.delete();
        push_idle(1, 1'b0);
        push_ramp(C_PC);
        push_seg(0, 1'b0, C_PC);
        push_seg(1, 1'b0, C_PC);
        push_seg(2, 1'b0, C_PC);
        push_seg(2, 1'b1, C_PC);
        push_seg(1, 1'b1, C_PC);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 0) enable = 1'b0;
            if (c == 1) begin enable = 1'b1; dir = 1'b0; end
            if (c == 28) dir = 1'b1;
            tick();
            e    = sb.pop_front();
            got  = {r_state, g_state, b_state, e.sv ? segment : e.seg, seg_done, running};
            want = {e.codes, e.seg, e.done, e.run};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL undo cyc %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_pause_step();
        exp_t e;
        logic [12:0] got, want;
        int n;
        sb.delete();
        push_idle(1, 1'b0);
        push_ramp(C_PC);
        push_seg(0, 1'b0, C_PC);
        push_seg(1, 1'b0, C_PC);
        push_pause(6'b11_10_11, 1, 4);
        push_seg(2, 1'b0, C_PC);
        push_pause(6'b11_10_10, 2, 4);
        push_seg(3, 1'b0, C_PC);
        push_pause(6'b11_11_10, 3, 1);
        push_seg(4, 1'b0, C_PC);
        push_seg(5, 1'b0, C_PC);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 0)  enable = 1'b0;
            if (c == 1)  begin enable = 1'b1; dir = 1'b0; end
            if (c == 20) pause_req = 1'b1;
            if (c == 29) step = 1'b1;
            if (c == 30) step = 1'b0;
            if (c == 41) begin step = 1'b1; pause_req = 1'b0; end
            if (c == 42) step = 1'b0;
            if (c == 52) step = 1'b1;
            if (c == 53) step = 1'b0;
            tick();
            e    = sb.pop_front();
            got  = {r_state, g_state, b_state, e.sv ? segment : e.seg, seg_done, running};
            want = {e.codes, e.seg, e.done, e.run};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL pause_step cyc %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_disable();
        exp_t e;
        logic [12:0] got, want;
        int n;
        sb.delete();
        push_idle(1, 1'b0);
        push_ramp(C_PC);
        for (int s = 0; s < 4; s++) push_seg(s, 1'b0, C_PC);
        push_seg(4, 1'b0, 4);
        push_idle(3, 1'b0);
        push_ramp(C_PC);
        push_seg(0, 1'b0, C_PC);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 0)  enable = 1'b0;
            if (c == 1)  begin enable = 1'b1; dir = 1'b0; end
            if (c == 45) enable = 1'b0;
            if (c == 48) enable = 1'b1;
            tick();
            e    = sb.pop_front();
            got  = {r_state, g_state, b_state, e.sv ? segment : e.seg, seg_done, running};
            want = {e.codes, e.seg, e.done, e.run};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL disable cyc %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [12:0] got, want;
        int n;
        sb.delete();
        push_idle(1, 1'b0);
        push_ramp(C_PC);
        push_seg(0, 1'b0, C_PC);
        push_seg(1, 1'b0, 3);
        push_idle(1, 1'b1);
        push_ramp(C_PC);
        push_seg(0, 1'b0, C_PC);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 0)  enable = 1'b0;
            if (c == 1)  begin enable = 1'b1; dir = 1'b0; end
            if (c == 20) rst_n = 1'b0;
            if (c == 21) rst_n = 1'b1;
            tick();
            e    = sb.pop_front();
            got  = {r_state, g_state, b_state, e.sv ? segment : e.seg, seg_done, running};
            want = {e.codes, e.seg, e.done, e.run};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL reset_mid cyc %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_forward();
        test_reverse();
        test_undo();
        test_pause_step();
        test_disable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
